spi_clock_scheduler: RTL

Round-robin scheduler that shares one SPI slow-clock divider among `NUM_REQ` requesters. It sits between the SPI transaction engines and the divider. For each granted requester it validates that requester's divisor, loads it into the divider, starts a single 8-slow-clock burst, and signals completion. Only one burst runs at a time, and a started burst is never aborted.

---
 rtl/spi_clock_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_clock_scheduler.sv
// Round-robin scheduler that shares one SPI slow-clock divider among NUM_REQ requesters.
// Each grant validates the divisor, loads it, starts one burst and reports done or err.
module spi_clock_scheduler #(
  parameter int NUM_REQ = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_cdiv,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [NUM_REQ-1:0]   o_done,
  output logic [NUM_REQ-1:0]   o_err,
  output logic                 o_busy,
  output logic [8:0]           o_div_config,
  output logic                 o_div_start_n,
  input  logic                 i_div_ready,
  output logic [2:0]           o_dbg_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_CONFIG    = 3'd2,
    S_START     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t               state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        idx_q;
  logic [7:0]           div_q;
  logic [1:0]           wait_cnt_q;
  logic [1:0]           retry_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   err_q;
  logic [8:0]           cfg_q;
  logic                 start_n_q;

  logic                 win_vld_d;
  logic [IW-1:0]        win_idx_d;
  logic [7:0]           win_div_d;
  logic [IW-1:0]        ptr_inc_d;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] k);
    onehot    = '0;
    onehot[k] = 1'b1;
  endfunction

  // Scan from the farthest offset down so the last hit is the first requester at/after ptr.
  always_comb begin
    int j;
    j         = 0;
    win_vld_d = 1'b0;
    win_idx_d = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (i_req[j]) begin
        win_vld_d = 1'b1;
        win_idx_d = IW'(j);
      end
    end
    win_div_d = i_cdiv[8*int'(win_idx_d) +: 8];
    ptr_inc_d = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      div_q      <= '0;
      wait_cnt_q <= '0;
      retry_q    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      cfg_q      <= '0;
      start_n_q  <= 1'b1;
    end else begin
      done_q    <= '0;
      err_q     <= '0;
      cfg_q     <= '0;
      start_n_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d && i_div_ready) begin
            idx_q   <= win_idx_d;
            div_q   <= win_div_d;
            state_q <= S_CHECK;
            // Rejection is flagged on entry so err is visible during CHECK.
            if (win_div_d == 8'd0 || win_div_d[0]) err_q <= onehot(win_idx_d);
          end
        end
        S_CHECK: begin
          if (div_q == 8'd0 || div_q[0]) begin
            ptr_q   <= ptr_inc_d;
            state_q <= S_IDLE;
          end else begin
            grant_q <= onehot(idx_q);
            cfg_q   <= {div_q, 1'b1};
            retry_q <= '0;
            state_q <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          start_n_q <= 1'b0;
          state_q   <= S_START;
        end
        S_START: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!i_div_ready) begin
            state_q <= S_WAIT_DONE;
          end else if (wait_cnt_q == 2'd3) begin
            wait_cnt_q <= '0;
            if (retry_q == 2'd3) begin
              // Give up on a silent divider; move ptr on so others are not starved.
              err_q   <= onehot(idx_q);
              grant_q <= '0;
              ptr_q   <= ptr_inc_d;
              state_q <= S_IDLE;
            end else begin
              retry_q   <= retry_q + 2'd1;
              start_n_q <= 1'b0;
              state_q   <= S_START;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        S_WAIT_DONE: begin
          if (i_div_ready) begin
            grant_q <= '0;
            done_q  <= onehot(idx_q);
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          ptr_q   <= ptr_inc_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_grant       = grant_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_div_config  = cfg_q;
  assign o_div_start_n = start_n_q;
  assign o_dbg_state   = state_q;

endmodule
